// File: rtl/iterative_multiplier.sv
// rtl/iterative_multiplier.sv - unsigned shift-and-add multiplier, one multiplier bit per clock
//
// Purpose: computes o_product = multiplicand * multiplier using one DATA_W-bit
//   adder. Each clock retires one multiplier bit, so a multiply takes DATA_W
//   iterations.
//
// Parameters:
//   DATA_W          operand width (>= 2); the product is 2*DATA_W bits wide
//
// Ports:
//   i_clk           clock; all state changes on the rising edge
//   i_rst           asynchronous, active-high reset
//   i_multiplicand  operand A, sampled when a start is accepted
//   i_multiplier    operand B, sampled when a start is accepted
//   i_start         single-cycle pulse requesting a multiply (ignored while busy)
//   o_busy          high from the cycle after an accepted start through DONE
//   o_product       last completed product, held until the next finish
//   o_finish        single-cycle pulse; o_product is valid in this cycle
module iterative_multiplier #(
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_W-1:0]     i_multiplicand,
  input  logic [DATA_W-1:0]     i_multiplier,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic [2*DATA_W-1:0]   o_product,
  output logic                  o_finish
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   mplr;
  logic [CNT_W-1:0]    count;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   acc_next;
  logic [DATA_W-1:0]   mplr_next;
  logic                last_iter;

  // The working register is {carry, acc, mplr}. The carry bit is shifted into
  // the acc MSB in the same step it is produced, so after every iteration it is
  // always zero and never needs to be stored; it lives only in sum[DATA_W].
  always_comb begin
    sum = {1'b0, acc};
    if (mplr[0]) begin
      sum = {1'b0, acc} + {1'b0, mcand};
    end
    acc_next  = sum[DATA_W:1];
    mplr_next = {sum[0], mplr[DATA_W-1:1]};
    last_iter = (count == CNT_W'(DATA_W - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      mplr      <= '0;
      count     <= '0;
      o_busy    <= 1'b0;
      o_finish  <= 1'b0;
      o_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_finish <= 1'b0;
          if (i_start) begin
            mcand  <= i_multiplicand;
            mplr   <= i_multiplier;
            acc    <= '0;
            count  <= '0;
            o_busy <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          mplr  <= mplr_next;
          count <= count + CNT_W'(1);
          // The product is captured on the same edge as the final iteration so
          // that o_finish in DONE coincides with the new value.
          if (last_iter) begin
            o_product <= {acc_next, mplr_next};
            o_finish  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          o_finish <= 1'b0;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          o_finish <= 1'b0;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_multiplier.sv
// tb/tb_iterative_multiplier.sv - self-checking bench for iterative_multiplier
module tb_iterative_multiplier;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          finish;
  logic [2*W-1:0] prod;

  // 8-bit instance
  logic           rst8 = 1'b1;
  logic           start8 = 1'b0;
  logic [W8-1:0]  a8 = '0;
  logic [W8-1:0]  b8 = '0;
  logic           busy8;
  logic           finish8;
  logic [2*W8-1:0] prod8;
  logic           done8 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  iterative_multiplier #(.DATA_W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_multiplicand(a), .i_multiplier(b),
    .i_start(start), .o_busy(busy), .o_product(prod), .o_finish(finish)
  );

  iterative_multiplier #(.DATA_W(W8)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_multiplicand(a8), .i_multiplier(b8),
    .i_start(start8), .o_busy(busy8), .o_product(prod8), .o_finish(finish8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an accepted start opens a window of W+1 busy cycles; the
  // product appears (with finish) in the last of them and is then held.
  int          m_left = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_prod = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_pend <= '0;
      m_prod <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left <= W + 1;
        m_pend <= 64'(a) * 64'(b);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_prod <= m_pend;
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 64'(busy), 64'(m_left != 0));
    check("cyc_finish", 64'(finish), 64'(m_left == 1));
    check("cyc_product", prod, m_prod);
  end

  // Waits for idle, starts a multiply, checks the held value mid-run, then the
  // latency and final product.
  task automatic do_mul(input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input logic [63:0] exp, input logic [63:0] held, input string tag);
    int guard;
    int cyc;
    guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check({tag, "_idle_wait"}, 64'(guard < 100), 64'd1);
    start = 1'b1; a = ma; b = mb;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    while (!finish && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 16) check({tag, "_held"}, prod, held);
    end
    check({tag, "_latency"}, 64'(cyc), 64'(W));
    check({tag, "_product"}, prod, exp);
  endtask

  // 8-bit instance: random back-to-back pairs, each started on the first idle cycle.
  initial begin : run8
    logic [W8-1:0] x, y;
    int guard, cyc;
    repeat (2) @(posedge clk);
    #1 rst8 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      x = W8'($urandom); y = W8'($urandom);
      if (i == 0) begin x = 8'hFF; y = 8'hFF; end
      guard = 0;
      while (busy8 && guard < 40) begin
        @(posedge clk); #1; guard++;
      end
      start8 = 1'b1; a8 = x; b8 = y;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = W8'($urandom); b8 = W8'($urandom);
      cyc = 0;
      while (!finish8 && cyc < 40) begin
        @(posedge clk); #1; cyc++;
      end
      check("w8_latency", 64'(cyc), 64'(W8));
      check("w8_product", 64'(prod8), 64'(16'(x) * 16'(y)));
    end
    done8 = 1'b1;
  end

  initial begin : main
    int bc, fin_at, cyc, guard;
    logic [W-1:0] r1, r2;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_finish", 64'(finish), 64'd0);
    check("reset_product", prod, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: 3*5, finish 32 cycles after start, busy for 33 cycles
    start = 1'b1; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    bc = 0; fin_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (busy) bc++;
      if (finish) fin_at = k;
      @(posedge clk); #1;
    end
    check("t1_finish_at", 64'(fin_at), 64'd32);
    check("t1_busy_cycles", 64'(bc), 64'd33);
    check("t1_product", prod, 64'd15);

    // 2: all-ones operands exercise the adder carry
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 64'd15, "t2");

    // 3: zero operands, previous product held while running
    do_mul(32'h1234, 32'h0, 64'd0, 64'hFFFF_FFFE_0000_0001, "t3a");
    do_mul(32'h0, 32'hDEAD, 64'd0, 64'd0, "t3b");

    // 4: start re-pulsed mid-run is ignored
    @(posedge clk); #1;
    start = 1'b1; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    repeat (9) begin @(posedge clk); #1; cyc++; end
    start = 1'b1; a = 32'd2; b = 32'd2;
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    while (!finish && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("t4_latency", 64'(cyc), 64'd32);
    check("t4_product", prod, 64'd63);
    do_mul(32'd6, 32'd7, 64'd42, 64'd63, "t4_next");

    // 5: reset in the middle of a multiply
    start = 1'b1; a = 32'hAB; b = 32'hCD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_finish", 64'(finish), 64'd0);
    check("t5_rst_product", prod, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    guard = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (finish) guard++;
    end
    check("t5_no_finish", 64'(guard), 64'd0);
    do_mul(32'hAB, 32'hCD, 64'h88EF, 64'd0, "t5_fresh");

    // 6: random back-to-back pairs
    for (int i = 0; i < 1000; i++) begin
      r1 = $urandom; r2 = $urandom;
      do_mul(r1, r2, 64'(r1) * 64'(r2), prod, "t6");
    end

    guard = 0;
    while (!done8 && guard < 20000) begin
      @(posedge clk); #1; guard++;
    end
    check("w8_done", 64'(done8), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
